controle_operacao: RTL and testbench
====================================

Name: controle_operacao

Overview:
- Upstream control stage for the two-operand calculator datapath. That datapath decodes results onto eight 7-segment displays, and its operation code input EA is supplied by this block.
- Synchronizes and debounces four raw pushbuttons (power, add, subtract, multiply) and runs the operation state machine that produces EA.
- Latches both 7-bit operands, saturated to 99, at the moment an operation is selected, so the datapath computes on stable values.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronized button level must hold before it is accepted (10 ms at 50 MHz); legal range >= 1
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
botao_liga  input  1  raw power pushbutton, active-low (0 = pressed), asynchronous to clk
botao1  input  1  raw add pushbutton, active-low
botao2  input  1  raw subtract pushbutton, active-low
botao3  input  1  raw multiply pushbutton, active-low
numero0  input  7  operand A switches, 0..127
numero1  input  7  operand B switches, 0..127
EA  output  3  operation code: off=0, on=1, soma=2, sub=3, mult=4; codes 5..7 are never driven
num0  output  7  latched operand A, range 0..99
num1  output  7  latched operand B, range 0..99
atualiza  output  1  one-cycle pulse on every edge at which EA, num0 or num1 is written

Behaviour:
- Reset (rst_n=0, effective immediately, no clock needed):
  - EA=0 (off), num0=0, num1=0, atualiza=0.
  - Synchronizer flops = 1 (released), debounced levels = released, counters = 0, press events = 0.
  - Reset mid-debounce discards any partial count. Release of reset is not itself a press.
- Synchronizer: each button passes through a 2-flop chain, s1 then s2.
- Debounce, per button, evaluated each edge:
  - If s2 == debounced level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: debounced <= s2 and counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Press event: a registered single-cycle pulse, set on the same edge the debounced level goes released->pressed. A release generates no event. Holding a button generates exactly one event.
- Latency: if the raw level changes before edge 1 and stays stable, s2 is valid after edge 2, the debounced level and event are set at edge DEBOUNCE_CYCLES+2, and EA/num0/num1/atualiza update at edge DEBOUNCE_CYCLES+3.
- FSM, evaluated only on cycles with at least one press event:
  - off: a liga event goes to on and clears num0/num1 to 0. All other events are ignored.
  - on, soma, sub or mult: a liga event goes to off (num0/num1 hold their values).
  - on, soma, sub or mult: a botao1/2/3 event goes to soma/sub/mult respectively and latches operands.
  - Re-pressing the current operation is legal: operands are re-latched and atualiza pulses again.
- Simultaneous events in one cycle: priority is liga > botao1 > botao2 > botao3. Lower-priority events in that cycle are dropped, not queued.
- Operand latch: num0 = (numero0 > 99) ? 99 : numero0; num1 is derived from numero1 the same way. The value is sampled on the update edge. Between updates num0/num1 hold regardless of switch changes.
- atualiza:
  - Asserted for exactly the cycle following every FSM update edge, including off<->on transitions and same-operation re-presses.
  - Never asserted for ignored events (operation buttons while off).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset and power-on (DEBOUNCE_CYCLES=4): after reset, hold botao_liga=0 for 20 cycles -> EA 0->1 exactly 7 edges after the first sampling edge; num0=num1=0; one atualiza pulse; no further pulses while held.
- Add with saturation: from on, set numero0=120 and numero1=45, press botao1 -> EA=2, num0=99, num1=45, atualiza one cycle. Then change switches to 10/10 -> num0/num1 unchanged.
- Bounce rejection: toggle botao2 low/high every 2 cycles for 30 cycles, then hold low -> EA stays unchanged during bouncing; it goes to 3 only DEBOUNCE_CYCLES+3 edges after the stable low begins, and only once.
- Priority and off-ignore:
  - From off, press botao3 alone -> EA stays 0, no atualiza.
  - From soma, assert botao_liga and botao3 so their events land in the same cycle -> EA=0 (off), num0/num1 hold.
- Re-press and async reset:
  - In mult with numero0=7, numero1=8, press botao3 again after setting numero0=12 -> EA=4, num0=12, atualiza pulses.
  - Then drop rst_n mid-debounce of botao1 -> all outputs 0 immediately; after release, no EA change without a fresh full press.

Source files
------------

// File: rtl/controle_operacao_if.sv
// Button, operand and result signals between the calculator front panel and
// the control stage. The master drives the panel side; the control stage is the slave.
interface controle_operacao_if;
  logic       botao_liga;
  logic       botao1;
  logic       botao2;
  logic       botao3;
  logic [6:0] numero0;
  logic [6:0] numero1;
  logic [2:0] EA;
  logic [6:0] num0;
  logic [6:0] num1;
  logic       atualiza;

  modport master (
    output botao_liga, botao1, botao2, botao3, numero0, numero1,
    input  EA, num0, num1, atualiza
  );

  modport slave (
    input  botao_liga, botao1, botao2, botao3, numero0, numero1,
    output EA, num0, num1, atualiza
  );
endinterface

// File: rtl/controle_operacao.sv
// Calculator control stage: synchronizes and debounces four active-low buttons,
// runs the operation FSM that drives EA, and latches saturated operands.
module controle_operacao #(
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  controle_operacao_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_ON   = 3'd1,
    ST_SOMA = 3'd2,
    ST_SUB  = 3'd3,
    ST_MULT = 3'd4
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'(DEBOUNCE_CYCLES - 1);

  // Button index: 0 = liga, 1 = soma, 2 = sub, 3 = mult.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] evt_q, evt_d;
  cnt_t       cnt_q [4];
  cnt_t       cnt_d [4];

  state_t     state_q, state_d;
  logic [6:0] num0_q, num0_d;
  logic [6:0] num1_q, num1_d;
  logic       atualiza_q, atualiza_d;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  assign btn_raw = {bus.botao3, bus.botao2, bus.botao1, bus.botao_liga};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    evt_d   = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        evt_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end
    end
  end

  // Liga outranks every operation button; operation buttons only act while powered.
  always_comb begin
    state_d    = state_q;
    num0_d     = num0_q;
    num1_d     = num1_q;
    atualiza_d = 1'b0;
    if (evt_q[0]) begin
      atualiza_d = 1'b1;
      if (state_q == ST_OFF) begin
        state_d = ST_ON;
        num0_d  = '0;
        num1_d  = '0;
      end else begin
        state_d = ST_OFF;
      end
    end else if (state_q != ST_OFF && evt_q[3:1] != 3'b000) begin
      atualiza_d = 1'b1;
      num0_d     = sat99(bus.numero0);
      num1_d     = sat99(bus.numero1);
      if (evt_q[1])      state_d = ST_SOMA;
      else if (evt_q[2]) state_d = ST_SUB;
      else               state_d = ST_MULT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      deb_q      <= 4'hF;
      evt_q      <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q    <= ST_OFF;
      num0_q     <= '0;
      num1_q     <= '0;
      atualiza_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      evt_q      <= evt_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      num0_q     <= num0_d;
      num1_q     <= num1_d;
      atualiza_q <= atualiza_d;
    end
  end

  assign bus.EA       = state_q;
  assign bus.num0     = num0_q;
  assign bus.num1     = num1_q;
  assign bus.atualiza = atualiza_q;

endmodule

// File: tb/tb_controle_operacao.sv
// Directed bench for controle_operacao with a short debounce window; expected
// values are hand-derived from the edge-level latency of the control stage.
module tb_controle_operacao;

  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   pulses;
  int   ea_bad;

  controle_operacao_if bus ();

  controle_operacao #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    repeat (n) begin
      tick(1);
      if (bus.atualiza === 1'b1) p++;
    end
  endtask

  task automatic applyStimulus(input logic l, input logic b1, input logic b2, input logic b3);
    bus.botao_liga = l;
    bus.botao1     = b1;
    bus.botao2     = b2;
    bus.botao3     = b3;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    bus.numero0 = 7'd0;
    bus.numero1 = 7'd0;

    tick(2);
    checkOutput("rst_EA", int'(bus.EA), 0);
    checkOutput("rst_num0", int'(bus.num0), 0);
    checkOutput("rst_num1", int'(bus.num1), 0);
    checkOutput("rst_atualiza", int'(bus.atualiza), 0);
    rst_n = 1'b1;
    tick(3);
    checkOutput("rst_release_EA", int'(bus.EA), 0);

    // Power on: hold liga 20 cycles.
    bus.numero0 = 7'd55;
    bus.numero1 = 7'd66;
    bus.botao_liga = 1'b0;
    tick(D + 2);
    checkOutput("on_early_EA", int'(bus.EA), 0);
    checkOutput("on_early_atualiza", int'(bus.atualiza), 0);
    tick(1);
    checkOutput("on_EA", int'(bus.EA), 1);
    checkOutput("on_num0", int'(bus.num0), 0);
    checkOutput("on_num1", int'(bus.num1), 0);
    checkOutput("on_atualiza", int'(bus.atualiza), 1);
    tick(1);
    checkOutput("on_atualiza_drop", int'(bus.atualiza), 0);
    count_pulses(12, pulses);
    checkOutput("on_hold_pulses", pulses, 0);
    bus.botao_liga = 1'b1;
    count_pulses(D + 4, pulses);
    checkOutput("on_release_pulses", pulses, 0);
    checkOutput("on_release_EA", int'(bus.EA), 1);

    // Add with saturation.
    bus.numero0 = 7'd120;
    bus.numero1 = 7'd45;
    bus.botao1  = 1'b0;
    tick(D + 2);
    checkOutput("soma_early_EA", int'(bus.EA), 1);
    tick(1);
    checkOutput("soma_EA", int'(bus.EA), 2);
    checkOutput("soma_num0_sat", int'(bus.num0), 99);
    checkOutput("soma_num1", int'(bus.num1), 45);
    checkOutput("soma_atualiza", int'(bus.atualiza), 1);
    tick(1);
    checkOutput("soma_atualiza_drop", int'(bus.atualiza), 0);
    bus.botao1  = 1'b1;
    bus.numero0 = 7'd10;
    bus.numero1 = 7'd10;
    tick(D + 4);
    checkOutput("soma_hold_num0", int'(bus.num0), 99);
    checkOutput("soma_hold_num1", int'(bus.num1), 45);

    // Bounce on botao2 for 30 cycles, then a stable press.
    ea_bad = 0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      bus.botao2 = (i % 2 == 1) ? 1'b0 : 1'b1;
      repeat (2) begin
        tick(1);
        if (bus.EA !== 3'd2) ea_bad++;
        if (bus.atualiza === 1'b1) pulses++;
      end
    end
    checkOutput("bounce_EA_stable", ea_bad, 0);
    checkOutput("bounce_pulses", pulses, 0);
    bus.botao2 = 1'b0;
    tick(D + 2);
    checkOutput("sub_early_EA", int'(bus.EA), 2);
    tick(1);
    checkOutput("sub_EA", int'(bus.EA), 3);
    checkOutput("sub_atualiza", int'(bus.atualiza), 1);
    count_pulses(10, pulses);
    checkOutput("sub_hold_pulses", pulses, 0);
    bus.botao2 = 1'b1;
    tick(D + 4);

    // Back to soma with 10/10, then liga+botao3 together.
    bus.botao1 = 1'b0;
    tick(D + 3);
    checkOutput("soma2_EA", int'(bus.EA), 2);
    checkOutput("soma2_num0", int'(bus.num0), 10);
    bus.botao1 = 1'b1;
    tick(D + 4);
    bus.numero0 = 7'd33;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(D + 3);
    checkOutput("prio_EA", int'(bus.EA), 0);
    checkOutput("prio_num0", int'(bus.num0), 10);
    checkOutput("prio_num1", int'(bus.num1), 10);
    checkOutput("prio_atualiza", int'(bus.atualiza), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick(D + 4);

    // Operation button while off is ignored.
    bus.botao3 = 1'b0;
    count_pulses(D + 8, pulses);
    checkOutput("off_ignore_EA", int'(bus.EA), 0);
    checkOutput("off_ignore_pulses", pulses, 0);
    bus.botao3 = 1'b1;
    tick(D + 4);

    // Power on, then mult, then re-press mult with new operand.
    bus.botao_liga = 1'b0;
    tick(D + 3);
    checkOutput("on2_EA", int'(bus.EA), 1);
    checkOutput("on2_num0", int'(bus.num0), 0);
    bus.botao_liga = 1'b1;
    tick(D + 4);
    bus.numero0 = 7'd7;
    bus.numero1 = 7'd8;
    bus.botao3  = 1'b0;
    tick(D + 3);
    checkOutput("mult_EA", int'(bus.EA), 4);
    checkOutput("mult_num0", int'(bus.num0), 7);
    checkOutput("mult_num1", int'(bus.num1), 8);
    bus.botao3 = 1'b1;
    tick(D + 4);
    bus.numero0 = 7'd12;
    bus.botao3  = 1'b0;
    tick(D + 2);
    checkOutput("remult_early_num0", int'(bus.num0), 7);
    tick(1);
    checkOutput("remult_EA", int'(bus.EA), 4);
    checkOutput("remult_num0", int'(bus.num0), 12);
    checkOutput("remult_num1", int'(bus.num1), 8);
    checkOutput("remult_atualiza", int'(bus.atualiza), 1);
    bus.botao3 = 1'b1;
    tick(D + 4);

    // Asynchronous reset in the middle of a botao1 debounce.
    bus.botao1 = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_EA", int'(bus.EA), 0);
    checkOutput("arst_num0", int'(bus.num0), 0);
    checkOutput("arst_num1", int'(bus.num1), 0);
    checkOutput("arst_atualiza", int'(bus.atualiza), 0);
    bus.botao1 = 1'b1;
    tick(2);
    rst_n = 1'b1;
    count_pulses(12, pulses);
    checkOutput("arst_after_EA", int'(bus.EA), 0);
    checkOutput("arst_after_pulses", pulses, 0);
    bus.botao_liga = 1'b0;
    tick(D + 3);
    checkOutput("arst_fresh_on_EA", int'(bus.EA), 1);
    bus.botao_liga = 1'b1;
    tick(D + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
